// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way registered arbiter, fixed-priority or round-robin,
// with a per-owner hold limit that yields to pending competitors.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 4,
  localparam int IW      = $clog2(N),
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  r,
  output logic [N-1:0]  g,
  output logic [IW-1:0] g_id,
  output logic          busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HW-1:0] MAX_H   = HW'(MAX_HOLD);
  localparam logic [HW-1:0] ONE_H   = HW'(1);
  localparam logic [IW:0]   N_W     = (IW + 1)'(N);
  localparam logic [N-1:0]  ONE_OH  = {{(N - 1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [N-1:0]  g_q;
  logic [IW-1:0] id_q;
  logic [IW-1:0] ptr_q;
  logic [HW-1:0] hold_q;
  logic          busy_q;

  logic [N-1:0]  cand;
  logic [IW-1:0] start;
  logic [IW:0]   sum;
  logic [IW:0]   nxt_sum;
  logic [IW-1:0] win;
  logic [IW-1:0] ptr_d;
  logic          found;
  logic          own_req;
  logic          others;
  logic          hold_max;

  // g_q is the owner's one-hot, so masking with it excludes the current owner
  always_comb begin
    cand     = r & ~g_q;
    own_req  = |(r & g_q);
    others   = |cand;
    hold_max = (hold_q == MAX_H);
    start    = (MODE == 1) ? ptr_q : '0;
    found    = 1'b0;
    win      = '0;
    sum      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (IW + 1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      if (!found && cand[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
    nxt_sum = {1'b0, win} + (IW + 1)'(1);
    ptr_d   = (nxt_sum >= N_W) ? '0 : nxt_sum[IW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= GRANT;
            g_q     <= ONE_OH << win;
            id_q    <= win;
            busy_q  <= 1'b1;
            hold_q  <= ONE_H;
            ptr_q   <= ptr_d;
          end
        end
        GRANT: begin
          // Hold count wraps to 1 when nobody is waiting, so a lone owner never stalls
          if (own_req && (!hold_max || !others)) begin
            hold_q <= hold_max ? ONE_H : hold_q + ONE_H;
          end else if (found) begin
            g_q    <= ONE_OH << win;
            id_q   <= win;
            hold_q <= ONE_H;
            ptr_q  <= ptr_d;
          end else begin
            state_q <= IDLE;
            g_q     <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign g    = g_q;
  assign g_id = id_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - directed vector bench for rr_arbiter_n in round-robin,
// fixed-priority and non-power-of-two configurations.
module tb_rr_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [3:0] r_a, r_b;
  logic [2:0] r_c;
  logic [3:0] g_a, g_b;
  logic [2:0] g_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic       busy_a, busy_b, busy_c;

  rr_arbiter_n #(.N(4), .MODE(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst_a), .r(r_a), .g(g_a), .g_id(gid_a), .busy(busy_a));
  rr_arbiter_n #(.N(4), .MODE(0), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst_b), .r(r_b), .g(g_b), .g_id(gid_b), .busy(busy_b));
  rr_arbiter_n #(.N(3), .MODE(1), .MAX_HOLD(2)) dut_c (
    .clk(clk), .rst(rst_c), .r(r_c), .g(g_c), .g_id(gid_c), .busy(busy_c));

  typedef struct {
    logic       rst;
    logic [3:0] r;
    logic [3:0] g;
  } vec_t;

  vec_t tv[$];
  int   passes = 0;
  int   checks = 0;

  function automatic logic [1:0] oh2id(input logic [3:0] v);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) id = 2'(i);
    return id;
  endfunction

  function automatic void add(input logic rs, input logic [3:0] rq, input logic [3:0] eg);
    vec_t v;
    v.rst = rs;
    v.r   = rq;
    v.g   = eg;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got {g,g_id,busy}=%h expected %h", name, act, exp);
  endtask

  task automatic step_b(input logic rs, input logic [3:0] rq, input logic [3:0] eg, input string name);
    @(negedge clk);
    rst_b = rs;
    r_b   = rq;
    @(posedge clk);
    #1;
    chk(name, {1'b0, g_b, gid_b, busy_b}, {1'b0, eg, oh2id(eg), |eg});
  endtask

  task automatic step_c(input logic rs, input logic [2:0] rq, input logic [2:0] eg, input string name);
    @(negedge clk);
    rst_c = rs;
    r_c   = rq;
    @(posedge clk);
    #1;
    chk(name, {2'b0, g_c, gid_c, busy_c}, {2'b0, eg, oh2id({1'b0, eg}), |eg});
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    r_a = '0; r_b = '0; r_c = '0;

    add(1, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0);
    repeat (6) add(0, 4'h1, 4'h1);
    add(0, 4'h0, 4'h0);
    add(1, 4'hf, 4'h0);
    for (int s = 0; s < 4; s++) repeat (4) add(0, 4'hf, 4'(1 << s));
    add(0, 4'hf, 4'h1);
    add(0, 4'h3, 4'h1);
    add(0, 4'h2, 4'h2);
    add(0, 4'h0, 4'h0);
    add(0, 4'h4, 4'h4);
    add(0, 4'h4, 4'h4);
    add(1, 4'hf, 4'h0);
    add(0, 4'hf, 4'h1);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst_a = tv[i].rst;
      r_a   = tv[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("rr_vec%0d", i), {1'b0, g_a, gid_a, busy_a},
          {1'b0, tv[i].g, oh2id(tv[i].g), |tv[i].g});
    end

    step_b(1, 4'h0, 4'h0, "fp_reset");
    repeat (4) step_b(0, 4'h6, 4'h2, "fp_0110_first");
    repeat (4) step_b(0, 4'h6, 4'h4, "fp_0110_second");
    step_b(0, 4'h6, 4'h2, "fp_0110_back");
    step_b(0, 4'h0, 4'h0, "fp_idle");
    step_b(0, 4'h4, 4'h4, "fp_0100");
    repeat (3) step_b(0, 4'h6, 4'h4, "fp_keep_until_max");
    step_b(0, 4'h6, 4'h2, "fp_yield");

    step_c(1, 3'h0, 3'h0, "n3_reset");
    repeat (2) step_c(0, 3'h7, 3'h1, "n3_owner0");
    repeat (2) step_c(0, 3'h7, 3'h2, "n3_owner1");
    repeat (2) step_c(0, 3'h7, 3'h4, "n3_owner2");
    step_c(0, 3'h7, 3'h1, "n3_wrap");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
